sn74hc595_trio_seg8_receiver: RTL and testbench

//  Receiver/monitor for the 3-digit 74HC595 serial display link (clk_serial/data/load).

---
 rtl/sn74hc595_trio_seg8_receiver.sv | 216 +++++++++++++++++++++
 tb/tb_sn74hc595_trio_seg8_receiver.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn74hc595_trio_seg8_receiver.sv
// Receiver/monitor for a 3-digit 74HC595 serial display link.
// Rebuilds the 24-bit chain and decodes the latched 7-seg characters.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   clk_serial, data  serial link; data sampled on clk_serial rise
//   load              storage latch; rise transfers the frame
//   seg2/seg1/seg0    latched raw characters (dp,g..a), active-low
//   num2/num1/num0    decoded BCD digits, 4'hF = undecodable
//   dp                lit decimal points, one bit per digit
//   frame_valid       one-cycle pulse per load rise
//   frame_err         qualifies frame_valid: short/long frame or bad digit
//   timeout           one-cycle pulse when a partial frame is aborted
//   frame_cnt         count of error-free frames, wraps
//   busy              link FSM is not idle
module sn74hc595_trio_seg8_receiver #(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_serial,
    input  logic       data,
    input  logic       load,
    output logic [7:0] seg2,
    output logic [7:0] seg1,
    output logic [7:0] seg0,
    output logic [3:0] num2,
    output logic [3:0] num1,
    output logic [3:0] num0,
    output logic [2:0] dp,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       timeout,
    output logic [7:0] frame_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [SYNC_STAGES-1:0] load_sync;

    logic sclk_prev;
    logic load_prev;

    // Registered edge pulses; the data bit is delayed alongside so
    // the three link signals stay aligned.
    logic sclk_rise;
    logic load_rise;
    logic data_q;

    logic [23:0] shift_reg;
    logic [4:0]  bit_cnt, bit_cnt_n, bit_cnt_inc;
    logic [15:0] idle_cnt;

    logic       timeout_hit;
    logic       do_timeout;
    logic [3:0] dec2, dec1, dec0;
    logic       err;

    function automatic logic [3:0] seg_decode(input logic [6:0] p);
        logic [3:0] d;
        case (p)
            7'h40:   d = 4'd0;
            7'h79:   d = 4'd1;
            7'h24:   d = 4'd2;
            7'h30:   d = 4'd3;
            7'h19:   d = 4'd4;
            7'h12:   d = 4'd5;
            7'h02:   d = 4'd6;
            7'h78:   d = 4'd7;
            7'h00:   d = 4'd8;
            7'h10:   d = 4'd9;
            default: d = 4'hF;
        endcase
        return d;
    endfunction

    // Synchronizers and edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            data_sync <= '0;
            load_sync <= '0;
            sclk_prev <= 1'b0;
            load_prev <= 1'b0;
            sclk_rise <= 1'b0;
            load_rise <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], clk_serial};
            data_sync <= {data_sync[SYNC_STAGES-2:0], data};
            load_sync <= {load_sync[SYNC_STAGES-2:0], load};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            load_prev <= load_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
            load_rise <= load_sync[SYNC_STAGES-1] & ~load_prev;
            data_q    <= data_sync[SYNC_STAGES-1];
        end
    end

    assign bit_cnt_inc = (bit_cnt == 5'd31) ? 5'd31 : bit_cnt + 5'd1;

    // A shift edge restarts the idle window, so it also blocks the abort.
    assign timeout_hit = (state != IDLE) && !sclk_rise &&
                         (idle_cnt == TIMEOUT_CYCLES - 16'd1);
    assign do_timeout  = timeout_hit && !load_rise;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= 5'd0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    // FSM next state
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        if (sclk_rise) begin
            bit_cnt_n = bit_cnt_inc;
        end
        case (state)
            IDLE: begin
                if (sclk_rise) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise && bit_cnt_inc >= 5'd24) begin
                    state_n = FULL;
                end
            end
            FULL: begin
                state_n = FULL;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // A load that coincides with a shift edge starts the next
        // frame with that bit already counted.
        if (load_rise) begin
            state_n   = sclk_rise ? SHIFT : IDLE;
            bit_cnt_n = sclk_rise ? 5'd1 : 5'd0;
        end else if (do_timeout) begin
            state_n   = IDLE;
            bit_cnt_n = 5'd0;
        end
    end

    assign busy = (state != IDLE);

    assign dec2 = seg_decode(shift_reg[22:16]);
    assign dec1 = seg_decode(shift_reg[14:8]);
    assign dec0 = seg_decode(shift_reg[6:0]);
    assign err  = (bit_cnt != 5'd24) || (dec2 == 4'hF) ||
                  (dec1 == 4'hF) || (dec0 == 4'hF);

    // Chain, idle timer and latched outputs. The latch reads the
    // pre-shift chain, like a 595 with both clocks tied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= 24'hFFFFFF;
            idle_cnt    <= 16'd0;
            seg2        <= 8'hFF;
            seg1        <= 8'hFF;
            seg0        <= 8'hFF;
            num2        <= 4'hF;
            num1        <= 4'hF;
            num0        <= 4'hF;
            dp          <= 3'b000;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            frame_valid <= load_rise;
            frame_err   <= load_rise & err;
            timeout     <= do_timeout;
            if (sclk_rise) begin
                shift_reg <= {shift_reg[22:0], data_q};
            end
            if (state_n == IDLE || sclk_rise) begin
                idle_cnt <= 16'd0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            if (load_rise) begin
                seg2 <= shift_reg[23:16];
                seg1 <= shift_reg[15:8];
                seg0 <= shift_reg[7:0];
                num2 <= dec2;
                num1 <= dec1;
                num0 <= dec0;
                dp   <= {~shift_reg[23], ~shift_reg[15], ~shift_reg[7]};
                if (!err) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sn74hc595_trio_seg8_receiver.sv
// Randomized scoreboard bench for sn74hc595_trio_seg8_receiver.
// A bit-history model predicts each latched frame and every abort.
module tb_sn74hc595_trio_seg8_receiver;

    localparam int          S  = 2;
    localparam int          H  = 3;
    localparam logic [15:0] TO = 16'd200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_serial = 1'b0;
    logic       data = 1'b0;
    logic       load = 1'b0;
    logic [7:0] seg2, seg1, seg0;
    logic [3:0] num2, num1, num0;
    logic [2:0] dp;
    logic       frame_valid, frame_err, timeout, busy;
    logic [7:0] frame_cnt;

    sn74hc595_trio_seg8_receiver #(
        .SYNC_STAGES(S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_serial(clk_serial),
        .data(data),
        .load(load),
        .seg2(seg2),
        .seg1(seg1),
        .seg0(seg0),
        .num2(num2),
        .num1(num1),
        .num0(num0),
        .dp(dp),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .timeout(timeout),
        .frame_cnt(frame_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] seg;
        logic [11:0] num;
        logic [2:0]  dp;
        logic        err;
        logic [7:0]  fcnt;
    } exp_t;

    exp_t q[$];
    bit   hist[$];
    int   m_cnt;
    int   m_fcnt;
    logic [23:0] m_last;
    int   exp_to;
    int   obs_to;
    int   checks;
    int   failures;

    logic [6:0] pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] ref_dec(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (pats[i] == p) return 4'(i);
        end
        return 4'hF;
    endfunction

    function automatic logic [7:0] rand_char();
        logic [7:0] c;
        if ($urandom_range(0, 9) == 0) begin
            c = 8'($urandom);
        end else begin
            c = {1'($urandom_range(0, 1)), pats[$urandom_range(0, 9)]};
        end
        return c;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 24; i++) hist.push_back(1'b1);
        m_cnt  = 0;
        m_fcnt = 0;
        m_last = 24'hFFFFFF;
    endtask

    task automatic model_shift(input bit b);
        hist.push_back(b);
        void'(hist.pop_front());
        m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
    endtask

    task automatic model_load();
        exp_t e;
        logic [23:0] s;
        logic [3:0] n2, n1, n0;
        for (int i = 0; i < 24; i++) s[23-i] = hist[i];
        n2 = ref_dec(s[22:16]);
        n1 = ref_dec(s[14:8]);
        n0 = ref_dec(s[6:0]);
        e.seg = s;
        e.num = {n2, n1, n0};
        e.dp  = {~s[23], ~s[15], ~s[7]};
        e.err = (m_cnt != 24) || n2 == 4'hF || n1 == 4'hF || n0 == 4'hF;
        if (!e.err) m_fcnt = (m_fcnt + 1) % 256;
        e.fcnt = 8'(m_fcnt);
        q.push_back(e);
        m_cnt  = 0;
        m_last = s;
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        data = b;
        clk_serial = 1'b0;
        repeat (H) @(negedge clk);
        clk_serial = 1'b1;
        model_shift(b);
        repeat (H) @(negedge clk);
        clk_serial = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load = 1'b1;
        model_load();
        repeat (H) @(negedge clk);
        load = 1'b0;
        repeat (H + 2) @(negedge clk);
    endtask

    task automatic load_with_bit(input bit b);
        @(negedge clk);
        data = b;
        clk_serial = 1'b0;
        repeat (H) @(negedge clk);
        clk_serial = 1'b1;
        load = 1'b1;
        model_load();
        model_shift(b);
        repeat (H) @(negedge clk);
        clk_serial = 1'b0;
        load = 1'b0;
        repeat (H + 2) @(negedge clk);
    endtask

    task automatic idle_abort();
        if (m_cnt > 0) exp_to++;
        m_cnt = 0;
        repeat (int'(TO) + 20) @(negedge clk);
        chk("busy_after_idle", 32'(busy), 32'd0);
        chk("seg_after_idle", 32'({seg2, seg1, seg0}), 32'(m_last));
        chk("timeout_count", 32'(obs_to), 32'(exp_to));
    endtask

    task automatic send_frame(input logic [23:0] f, input int nbits);
        if (nbits > 24) begin
            for (int i = 0; i < nbits - 24; i++) send_bit(1'($urandom));
            for (int i = 23; i >= 0; i--) send_bit(f[i]);
        end else begin
            for (int i = nbits - 1; i >= 0; i--) send_bit(f[i]);
        end
    endtask

    // Monitor: pops one expectation per frame_valid pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (timeout) obs_to++;
            if (frame_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got frame_valid=1 expected none at %0t",
                             $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("seg", 32'({seg2, seg1, seg0}), 32'(e.seg));
                    chk("num", 32'({num2, num1, num0}), 32'(e.num));
                    chk("dp", 32'(dp), 32'(e.dp));
                    chk("frame_err", 32'(frame_err), 32'(e.err));
                    chk("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
                end
            end else begin
                if (frame_err) begin
                    checks++;
                    failures++;
                    $display("FAIL err_without_valid: got frame_err=1 expected 0 at %0t",
                             $time);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        exp_to = 0;
        obs_to = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'({seg2, seg1, seg0}), 32'h00FFFFFF);
        chk("rst_num", 32'({num2, num1, num0}), 32'h00000FFF);
        chk("rst_flags", 32'({dp, frame_valid, frame_err, timeout, busy}), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_byte(8'hA4);
        send_byte(8'h79);
        send_byte(8'hB0);
        pulse_load();
        chk("t1_num", 32'({num2, num1, num0}), 32'h213);
        chk("t1_dp", 32'(dp), 32'b010);
        chk("t1_cnt", 32'(frame_cnt), 32'd1);

        send_frame(24'hA479B0, 23);
        pulse_load();
        chk("t2_cnt", 32'(frame_cnt), 32'd1);

        send_frame(24'hA479B0, 26);
        pulse_load();
        chk("t3_num", 32'({num2, num1, num0}), 32'h213);

        send_frame(24'h123456, 10);
        idle_abort();
        send_frame(24'hF9C0A4, 24);
        pulse_load();
        chk("t4_num", 32'({num2, num1, num0}), 32'h102);

        send_frame(24'hA479FF, 24);
        pulse_load();
        send_frame(24'h808000, 24);
        pulse_load();
        chk("t5_num", 32'({num2, num1, num0}), 32'h888);
        chk("t5_dp", 32'(dp), 32'b001);

        pulse_load();
        send_frame(24'hA479B0, 23);
        load_with_bit(1'b0);
        chk("sim_busy", 32'(busy), 32'd1);
        idle_abort();

        for (int n = 0; n < 40; n++) begin
            logic [23:0] f;
            int nb;
            f = {rand_char(), rand_char(), rand_char()};
            case ($urandom_range(0, 9))
                0: nb = 0;
                1, 2: nb = $urandom_range(1, 30);
                default: nb = 24;
            endcase
            send_frame(f, nb);
            if ($urandom_range(0, 7) == 0) idle_abort();
            else if ($urandom_range(0, 7) == 0) load_with_bit(1'($urandom));
            else pulse_load();
        end
        idle_abort();

        chk("drain_before_reset", 32'(q.size()), 32'd0);
        send_frame(24'hA479B0, 12);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_seg", 32'({seg2, seg1, seg0}), 32'h00FFFFFF);
        chk("mid_rst_num", 32'({num2, num1, num0}), 32'h00000FFF);
        chk("mid_rst_flags",
            32'({dp, frame_valid, frame_err, timeout, busy}), 32'd0);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int n = 0; n < 256; n++) begin
            logic [23:0] f;
            f = {1'b1, pats[$urandom_range(0, 9)], 1'($urandom),
                 pats[$urandom_range(0, 9)], 1'b0, pats[$urandom_range(0, 9)]};
            send_frame(f, 24);
            pulse_load();
        end
        chk("wrap_cnt", 32'(frame_cnt), 32'd0);

        repeat (20) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("timeout_total", 32'(obs_to), 32'(exp_to));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
